sobel_window_ctrl: RTL
======================

Name: sobel_window_ctrl

Overview:
Sequences a raster pixel stream into 3x3 neighbourhoods and drives the Gx convolution stage. It holds two line buffers plus a 3-column tap window. It presents the six taps the Gx kernel uses (positions 1,3,4,6,7,9) and asserts the Gx stage enable only for windows that are fully inside the image. It sits between the pixel source (frame memory or DMA) and the Gx/Gy calculation units of the Sobel accelerator.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
PIX_W, 4, pixel width in bits

Ports:
Clk  in  1  system clock, all logic on posedge
Rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begins a frame when idle
pix_in  in  PIX_W  raster-order input pixel
pix_in_valid  in  1  pix_in is valid
pix_in_ready  out  1  controller accepts pix_in this cycle
out_ready  in  1  downstream can take the current window
win_valid  out  1  tap outputs hold a valid window
p1,p3,p4,p6,p7,p9  out  PIX_W each  window taps (p1 top-left, p9 bottom-right)
gx_enable  out  1  enable to Gx stage, equals win_valid && out_ready
row_idx  out  $clog2(IMG_H)  row of the centre pixel of the current window
col_idx  out  $clog2(IMG_W)  column of the centre pixel of the current window
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last window is consumed

Behaviour:
- Reset: the state machine returns to IDLE. All outputs are 0: taps, win_valid, gx_enable, busy, done, pix_in_ready, row_idx, col_idx. Counters and line buffers are cleared. Reset asserted mid-frame aborts the frame with no done pulse.
- Acceptance rule: a pixel is accepted when pix_in_valid && pix_in_ready.
- FSM states:
  - IDLE: on start go to RUN and set busy=1.
  - RUN: accept pixels. pix_in_ready = 1 when (!win_valid || out_ready) and the pixel count is < IMG_W*IMG_H.
  - DRAIN: entered after the last pixel is accepted. Waits until the final window is consumed, then goes to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Counters: in_row and in_col track the accepted pixel. in_col wraps from IMG_W-1 to 0 and increments in_row. Each accepted pixel shifts into the line buffers and the tap window.
- Window generation: accepting pixel (r,c) with r>=2 and c>=2 sets win_valid on the next cycle. Taps come from rows r-2..r and columns c-2..c. row_idx=r-1, col_idx=c-1.
- No padding: exactly (IMG_W-2)*(IMG_H-2) windows per frame. Columns 0 and 1 of each row never produce a window; the tap window still shifts across the row wrap.
- Latency: 1 cycle from accepting the pixel to win_valid.
- Backpressure: while win_valid && !out_ready, taps and indices stay stable and pix_in_ready=0.
- Consumption: on out_ready, win_valid clears unless a new window is loaded in the same cycle. Consume and load in the same cycle is legal and gives back-to-back windows.
- Input bubbles: pix_in_valid=0 holds all state; win_valid is unaffected.
- start while busy is ignored.
- Arithmetic: none beyond counters. Counters use the declared widths and wrap exactly at the IMG bounds.

Optional Feature:
Macro GX_SUM_EN.
- Defined: adds output gx_sum (signed, PIX_W+3 bits), computed combinationally from the registered taps as p1 - p3 + 2*p4 - 2*p6 + p7 - p9. All terms are zero-extended before the signed math. gx_sum is valid whenever win_valid=1 and is 0 after reset.
- Not defined: the port and adder are absent; taps only.

Decomposition:
- Package sobel_pkg holds:
  - pix_t (logic [PIX_W-1:0])
  - state_t enum {IDLE, RUN, DRAIN, DONE}
  - GX_W = PIX_W+3
  - default IMG_W/IMG_H constants
- Sub-module sobel_line_buf: IMG_W-deep shift register with shift enable and synchronous clear. Instantiated twice (row-1 and row-2 delay lines).

Test Plan:
1. IMG_W=IMG_H=4, pixels = (4*row+col), continuous valid, out_ready=1
   -> 4 windows. First win_valid comes 1 cycle after the 11th pixel is accepted, with taps p1..p9 = 0,2,4,6,8,10. Windows appear at (row_idx,col_idx) = (1,1),(1,2),(2,1),(2,2). done pulses once, then busy=0.
2. Same frame, out_ready=0 for 3 cycles while win_valid=1
   -> taps are stable, pix_in_ready=0, gx_enable=0. No pixel is lost and all 4 windows arrive with correct taps.
3. Same frame, pix_in_valid toggled 1,0,1,0...
   -> identical window sequence, and the counters do not advance on bubbles.
4. Rst asserted for 1 cycle after the 9th pixel, then a new start and a full frame
   -> all outputs are 0 in the cycle after reset, there is no done from the aborted frame, and the second frame behaves as in test 1.
5. start pulsed while busy=1
   -> ignored: one done only, window count is 4.
6. GX_SUM_EN defined, the frame from test 1
   -> every window gives gx_sum = -8 (7'b1111000). gx_sum = 0 after reset.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel window controller slice.
package sobel_pkg;
  localparam int DEF_IMG_W = 8;
  localparam int DEF_IMG_H = 8;
  localparam int DEF_PIX_W = 4;
  localparam int GX_W      = DEF_PIX_W + 3;

  typedef logic [DEF_PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/sobel_line_buf.sv
// One-row delay line: DEPTH-stage shift register advanced only on accepted pixels.
module sobel_line_buf
  import sobel_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int W     = DEF_PIX_W
) (
  input  logic         Clk,
  input  logic         clr,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster-to-3x3 window sequencer feeding the Gx stage; optional GX_SUM_EN adds a combinational Gx sum.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = DEF_PIX_W
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic [PIX_W-1:0]         pix_in,
  input  logic                     pix_in_valid,
  output logic                     pix_in_ready,
  input  logic                     out_ready,
  output logic                     win_valid,
  output logic [PIX_W-1:0]         p1,
  output logic [PIX_W-1:0]         p3,
  output logic [PIX_W-1:0]         p4,
  output logic [PIX_W-1:0]         p6,
  output logic [PIX_W-1:0]         p7,
  output logic [PIX_W-1:0]         p9,
  output logic                     gx_enable,
  output logic [$clog2(IMG_H)-1:0] row_idx,
  output logic [$clog2(IMG_W)-1:0] col_idx,
  output logic                     busy,
  output logic                     done
`ifdef GX_SUM_EN
  ,
  output logic signed [PIX_W+2:0]  gx_sum
`endif
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  state_t           state;
  logic [RW-1:0]    in_row;
  logic [CW-1:0]    in_col;
  logic [PIX_W-1:0] win [3][3];
  logic [PIX_W-1:0] lb1_out, lb2_out;
  logic             accept, last_pix, lb_clr, col_wrap;

  assign pix_in_ready = (state == RUN) && (!win_valid || out_ready);
  assign accept       = pix_in_valid && pix_in_ready;
  assign gx_enable    = win_valid && out_ready;
  assign col_wrap     = (in_col == CW'(IMG_W-1));
  assign last_pix     = col_wrap && (in_row == RW'(IMG_H-1));
  assign lb_clr       = Rst || ((state == IDLE) && start);

  sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb1 (
    .Clk(Clk), .clr(lb_clr), .shift_en(accept), .din(pix_in), .dout(lb1_out)
  );

  sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W)) u_lb2 (
    .Clk(Clk), .clr(lb_clr), .shift_en(accept), .din(lb1_out), .dout(lb2_out)
  );

  // Window rows are top/mid/bottom; column 2 always holds the newest pixel column.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      in_row    <= '0;
      in_col    <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2_out;
        win[1][2] <= lb1_out;
        win[2][2] <= pix_in;
        win_valid <= (in_row >= RW'(2)) && (in_col >= CW'(2));
        if ((in_row >= RW'(2)) && (in_col >= CW'(2))) begin
          row_idx <= in_row - RW'(1);
          col_idx <= in_col - CW'(1);
        end
        if (col_wrap) begin
          in_col <= '0;
          in_row <= (in_row == RW'(IMG_H-1)) ? '0 : in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end else if (out_ready) begin
        win_valid <= 1'b0;
      end

      case (state)
        IDLE:  if (start) begin
                 state <= RUN;
                 busy  <= 1'b1;
               end
        RUN:   if (accept && last_pix) state <= DRAIN;
        DRAIN: if (!win_valid || out_ready) begin
                 state <= DONE;
                 done  <= 1'b1;
                 busy  <= 1'b0;
               end
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign p1 = win[0][0];
  assign p3 = win[0][2];
  assign p4 = win[1][0];
  assign p6 = win[1][2];
  assign p7 = win[2][0];
  assign p9 = win[2][2];

`ifdef GX_SUM_EN
  function automatic logic signed [PIX_W+2:0] zext(input logic [PIX_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  assign gx_sum = zext(p1) - zext(p3) + (zext(p4) <<< 1) - (zext(p6) <<< 1)
                + zext(p7) - zext(p9);
`endif

endmodule
